// File: rtl/dm_responder_if.sv
// M->W data-memory bus between the core pipeline and dm_responder.
// The core side uses the master modport; the responder uses the slave modport.
interface dm_responder_if;
  logic        M_req;
  logic [31:0] M_addr;
  logic [3:0]  M_byteen;
  logic [31:0] M_wdata;
  logic [31:0] M_PC;
  logic        Req;
  logic        M_W_REG_EN;
  logic [31:0] W_DMout;
  logic        W_DMerr;
  logic        busy;

  modport master (
    output M_req, M_addr, M_byteen, M_wdata, M_PC, Req, M_W_REG_EN,
    input  W_DMout, W_DMerr, busy
  );

  modport slave (
    input  M_req, M_addr, M_byteen, M_wdata, M_PC, Req, M_W_REG_EN,
    output W_DMout, W_DMerr, busy
  );
endinterface

// File: rtl/dm_responder.sv
// dm_responder: data memory at the far end of the M->W path.
// Byte-enabled writes, read-before-write registered read into the W stage,
// honours freeze (M_W_REG_EN=0) and flush (Req=1), and zero-fills the
// array after reset while holding busy high.
// Optional macro DM_WRITE_LOG_EN: prints every committed write as
// "@<pc>: *<word addr> <= <merged word>".
module dm_responder #(
  parameter int DEPTH  = 3072,
  parameter int ADDR_W = 12
) (
  input logic         clk,
  input logic         reset,
  dm_responder_if.slave bus
);

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    READY = 2'd1
  } state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   clr_ptr_reg, clr_ptr_next;

  logic [ADDR_W-1:0]   idx;
  logic                inr;
  logic                commit;
  logic [3:0]          mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [31:0]         mem_wdata;
  logic [31:0]         rd_word;
  logic [31:0]         dm_out_reg;
  logic                dm_err_reg;

  // The PC only feeds the optional write log; address bits [1:0] are don't-care.
  logic unused_bits;
  assign unused_bits = ^{bus.M_PC, bus.M_addr[1:0]};

  assign idx    = bus.M_addr[ADDR_W+1:2];
  assign inr    = (bus.M_addr < 32'(DEPTH * 4));
  // A store commits only when it is in range, advancing, and not flushed.
  assign commit = bus.M_req & (|bus.M_byteen) & inr & bus.M_W_REG_EN & ~bus.Req;

  // State and clear-pointer registers; reset restarts the clear from word 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= CLEAR;
      clr_ptr_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_ptr_reg <= clr_ptr_next;
    end
  end

  // Next state and memory write port selection (clear sweep or core store).
  always_comb begin
    state_next   = state_reg;
    clr_ptr_next = clr_ptr_reg;
    mem_we       = 4'b0000;
    mem_waddr    = idx;
    mem_wdata    = bus.M_wdata;
    case (state_reg)
      CLEAR: begin
        mem_we    = 4'b1111;
        mem_waddr = clr_ptr_reg;
        mem_wdata = 32'h0;
        if (clr_ptr_reg == ADDR_W'(DEPTH - 1)) begin
          state_next   = READY;
          clr_ptr_next = '0;
        end else begin
          clr_ptr_next = clr_ptr_reg + 1'b1;
        end
      end
      READY: begin
        if (commit) begin
          mem_we = bus.M_byteen;
        end
      end
      default: begin
        state_next   = CLEAR;
        clr_ptr_next = '0;
      end
    endcase
  end

  // One byte-wide array per lane so each strobe maps onto its own write enable.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];

    // Lane write; the array itself is never reset (the clear sweep zeroes it).
    always_ff @(posedge clk) begin
      if (mem_we[gi]) begin
        lane_mem[mem_waddr] <= mem_wdata[8*gi +: 8];
      end
    end

    assign rd_word[8*gi +: 8] = lane_mem[idx];
  end

  // W-stage read register: flush clears, freeze holds, otherwise capture
  // the pre-write word (or zero) and the out-of-range flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dm_out_reg <= 32'h0;
      dm_err_reg <= 1'b0;
    end else if (state_reg == READY) begin
      if (bus.Req) begin
        dm_out_reg <= 32'h0;
        dm_err_reg <= 1'b0;
      end else if (bus.M_W_REG_EN) begin
        dm_out_reg <= (bus.M_req & inr) ? rd_word : 32'h0;
        dm_err_reg <= bus.M_req & ~inr;
      end
    end
  end

  assign bus.W_DMout = dm_out_reg;
  assign bus.W_DMerr = dm_err_reg;
  assign bus.busy    = (state_reg == CLEAR);

`ifdef DM_WRITE_LOG_EN
  logic [31:0] merged_word;

  for (genvar gi = 0; gi < 4; gi++) begin : g_merge
    assign merged_word[8*gi +: 8] = mem_we[gi] ? mem_wdata[8*gi +: 8] : rd_word[8*gi +: 8];
  end

  // Log committed core stores only; the clear sweep stays silent.
  always_ff @(posedge clk) begin
    if (reset && state_reg == READY && commit) begin
      $display("@%h: *%h <= %h", bus.M_PC, {bus.M_addr[31:2], 2'b00}, merged_word);
    end
  end
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: directed accesses push expected W-stage results into
// a scoreboard queue tagged with the cycle they are due; a monitor pops and
// compares on the falling edge of that cycle.
module tb_dm_responder;
  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;

  dm_responder_if bus ();

  dm_responder #(.DEPTH(3072), .ADDR_W(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  // Scoreboard monitor: one pop per due cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      if (exp_q[0].due == cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (bus.W_DMout !== e.data || bus.W_DMerr !== e.err) begin
          errors++;
          $display("FAIL %s: W_DMout=%h W_DMerr=%b expected %h %b",
                   e.name, bus.W_DMout, bus.W_DMerr, e.data, e.err);
        end else begin
          $display("ok   %s: W_DMout=%h W_DMerr=%b", e.name, bus.W_DMout, bus.W_DMerr);
        end
      end else if (exp_q[0].due < cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL %s: result slot missed at cycle %0d expected %h", e.name, cyc, e.data);
      end
    end
  end

  // One M-stage cycle; the result is due one clock later.
  task automatic access(input string nm, input logic rq, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd, input logic fl,
                        input logic en, input logic [31:0] ed, input logic ee);
    exp_t e;
    @(posedge clk);
    #1;
    bus.M_req      = rq;
    bus.M_addr     = a;
    bus.M_byteen   = be;
    bus.M_wdata    = wd;
    bus.M_PC       = 32'h0000_4000 + 32'(cyc * 4);
    bus.Req        = fl;
    bus.M_W_REG_EN = en;
    e.due  = cyc + 1;
    e.data = ed;
    e.err  = ee;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic en);
    @(posedge clk);
    #1;
    bus.M_req      = 1'b0;
    bus.M_byteen   = 4'b0000;
    bus.Req        = 1'b0;
    bus.M_W_REG_EN = en;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d results never compared", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Counts falling edges that see busy high, bounded.
  task automatic count_busy(input string nm);
    int n;
    n = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (bus.busy) n++;
      else break;
    end
    chk(nm, 32'(n), 32'd3072);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0;
    checks = 0;
    errors = 0;
    reset = 1'b0;
    bus.M_req = 1'b0;
    bus.M_addr = 32'h0;
    bus.M_byteen = 4'b0000;
    bus.M_wdata = 32'h0;
    bus.M_PC = 32'h0;
    bus.Req = 1'b0;
    bus.M_W_REG_EN = 1'b1;

    #3;
    chk("reset_busy", 32'(bus.busy), 32'd1);
    chk("reset_dmout", bus.W_DMout, 32'h0);
    chk("reset_dmerr", 32'(bus.W_DMerr), 32'd0);

    @(posedge clk);
    #1;
    reset = 1'b1;
    count_busy("clear_cycles");

    access("load_0000", 1, 32'h0000_0000, 4'b0000, 32'h0, 0, 1, 32'h0, 0);
    access("load_2ffc", 1, 32'h0000_2FFC, 4'b0000, 32'h0, 0, 1, 32'h0, 0);
    access("store_word_rbw", 1, 32'h0000_0010, 4'b1111, 32'h1234_5678, 0, 1, 32'h0, 0);
    access("load_word", 1, 32'h0000_0010, 4'b0000, 32'h0, 0, 1, 32'h1234_5678, 0);
    access("store_lane1_rbw", 1, 32'h0000_0010, 4'b0010, 32'hAABB_CCDD, 0, 1, 32'h1234_5678, 0);
    access("load_lane1", 1, 32'h0000_0010, 4'b0000, 32'h0, 0, 1, 32'h1234_CC78, 0);
    access("store_flushed", 1, 32'h0000_0010, 4'b1111, 32'hFFFF_FFFF, 1, 1, 32'h0, 0);
    access("load_after_flush", 1, 32'h0000_0010, 4'b0000, 32'h0, 0, 1, 32'h1234_CC78, 0);
    for (int k = 0; k < 3; k++)
      access($sformatf("freeze_hold%0d", k), 1, 32'h0000_0010, 4'b1111, 32'h0, 0, 0, 32'h1234_CC78, 0);
    access("load_after_freeze", 1, 32'h0000_0010, 4'b0000, 32'h0, 0, 1, 32'h1234_CC78, 0);
    access("load_oor", 1, 32'h0000_3000, 4'b0000, 32'h0, 0, 1, 32'h0, 1);
    access("store_oor", 1, 32'h0000_3000, 4'b1111, 32'hDEAD_BEEF, 0, 1, 32'h0, 1);
    access("store_oor_alias", 1, 32'h0000_4010, 4'b1111, 32'hDEAD_BEEF, 0, 1, 32'h0, 1);
    access("load_after_oor", 1, 32'h0000_0010, 4'b0000, 32'h0, 0, 1, 32'h1234_CC78, 0);
    access("flush_over_freeze", 1, 32'h0000_0010, 4'b0000, 32'h0, 1, 0, 32'h0, 0);
    access("no_req_idle", 0, 32'h0000_0010, 4'b0000, 32'h0, 0, 1, 32'h0, 0);
    access("store_top_rbw", 1, 32'h0000_2FFC, 4'b1001, 32'h1122_3344, 0, 1, 32'h0, 0);
    access("load_top", 1, 32'h0000_2FFC, 4'b0000, 32'h0, 0, 1, 32'h1100_0044, 0);
    access("load_before_reset", 1, 32'h0000_0010, 4'b0000, 32'h0, 0, 1, 32'h1234_CC78, 0);
    idle(1'b0);
    drain();

    // Asynchronous reset while the read register holds data.
    #1;
    reset = 1'b0;
    #1;
    chk("async_reset_dmout", bus.W_DMout, 32'h0);
    chk("async_reset_busy", 32'(bus.busy), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 100; i++) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midclear_busy", 32'(bus.busy), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    count_busy("reclear_cycles");

    access("load_0010_cleared", 1, 32'h0000_0010, 4'b0000, 32'h0, 0, 1, 32'h0, 0);
    access("load_2ffc_cleared", 1, 32'h0000_2FFC, 4'b0000, 32'h0, 0, 1, 32'h0, 0);
    idle(1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
